// File: rtl/bounce_emulator.sv
// Synthesizable bouncy push-button waveform source for debouncer self-test.
// Define BOUNCE_GLITCH_EN to add a one-cycle noise spike at SETTLE index 2.
module bounce_emulator #(
  parameter int          HOLD_BITS     = 8,
  parameter int          SETTLE_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk_10mhz,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           bounce_cnt,
  input  logic [HOLD_BITS-1:0] hold_cycles,
  output logic                 btn_out,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           press_count
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int WIDE_W   = (HOLD_BITS > SETTLE_W) ? HOLD_BITS : SETTLE_W;
  localparam int CNT_W    = (WIDE_W > 4) ? WIDE_W : 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    SETTLE
  } state_t;

  state_t               state_reg, state_next;
  logic [15:0]          lfsr_reg, lfsr_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 level_reg, level_next;
  logic [3:0]           bounces_reg, bounces_next;
  logic [3:0]           h_len_reg, h_len_next;
  logic [3:0]           l_len_reg, l_len_next;
  logic [2:0]           rel_lat_reg, rel_lat_next;
  logic [HOLD_BITS-1:0] hold_lat_reg, hold_lat_next;
  logic [7:0]           press_count_reg, press_count_next;
  logic                 btn_reg, btn_next;

  logic                 load;
  logic [15:0]          lfsr_step;
  logic [3:0]           new_h;
  logic [3:0]           new_l;
  logic [HOLD_BITS-1:0] hold_eff;
  logic                 settle_glitch;

  // Fibonacci LFSR, taps 16,14,13,11; phase lengths come from the pre-step value.
  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign new_h     = 4'd1 + {1'b0, lfsr_reg[2:0]};
  assign new_l     = 4'd1 + {1'b0, lfsr_reg[5:3]};
  assign hold_eff  = (hold_cycles == '0) ? HOLD_BITS'(1) : hold_cycles;

  always_comb begin
    state_next       = state_reg;
    lfsr_next        = lfsr_reg;
    cnt_next         = cnt_reg;
    level_next       = level_reg;
    bounces_next     = bounces_reg;
    h_len_next       = h_len_reg;
    l_len_next       = l_len_reg;
    rel_lat_next     = rel_lat_reg;
    hold_lat_next    = hold_lat_reg;
    press_count_next = press_count_reg;
    load             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          rel_lat_next  = bounce_cnt[3:1];
          hold_lat_next = hold_eff;
          if (bounce_cnt != 4'd0) begin
            state_next   = PRESS_BOUNCE;
            bounces_next = bounce_cnt;
            level_next   = 1'b1;
            cnt_next     = CNT_W'(new_h);
            load         = 1'b1;
          end else begin
            state_next = HOLD;
            cnt_next   = CNT_W'(hold_eff);
          end
        end
      end

      PRESS_BOUNCE: begin
        if (cnt_reg != CNT_ONE) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (level_reg) begin
          level_next = 1'b0;
          cnt_next   = CNT_W'(l_len_reg);
        end else if (bounces_reg != 4'd1) begin
          bounces_next = bounces_reg - 4'd1;
          level_next   = 1'b1;
          cnt_next     = CNT_W'(new_h);
          load         = 1'b1;
        end else begin
          state_next = HOLD;
          cnt_next   = CNT_W'(hold_lat_reg);
        end
      end

      HOLD: begin
        if (cnt_reg != CNT_ONE) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rel_lat_reg != 3'd0) begin
          state_next   = RELEASE_BOUNCE;
          bounces_next = {1'b0, rel_lat_reg};
          level_next   = 1'b0;
          cnt_next     = CNT_W'(new_l);
          load         = 1'b1;
        end else begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end

      // Release bounces start low: the contact opens, then chatters closed.
      RELEASE_BOUNCE: begin
        if (cnt_reg != CNT_ONE) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (!level_reg) begin
          level_next = 1'b1;
          cnt_next   = CNT_W'(h_len_reg);
        end else if (bounces_reg != 4'd1) begin
          bounces_next = bounces_reg - 4'd1;
          level_next   = 1'b0;
          cnt_next     = CNT_W'(new_l);
          load         = 1'b1;
        end else begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        if (cnt_reg != CNT_ONE) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          state_next       = IDLE;
          press_count_next = press_count_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (load) begin
      lfsr_next  = lfsr_step;
      h_len_next = new_h;
      l_len_next = new_l;
    end
  end

`ifdef BOUNCE_GLITCH_EN
  localparam logic [CNT_W-1:0] GLITCH_AT = CNT_W'(SETTLE_CYCLES - 2);
  assign settle_glitch = (state_next == SETTLE) && (cnt_next == GLITCH_AT);
`else
  assign settle_glitch = 1'b0;
`endif

  // btn_out is registered from the next state so the pin never glitches on decode.
  always_comb begin
    btn_next = 1'b0;
    case (state_next)
      PRESS_BOUNCE:   btn_next = level_next;
      HOLD:           btn_next = 1'b1;
      RELEASE_BOUNCE: btn_next = level_next;
      SETTLE:         btn_next = settle_glitch;
      default:        btn_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_10mhz) begin
    if (rst) begin
      state_reg       <= IDLE;
      lfsr_reg        <= SEED;
      cnt_reg         <= '0;
      level_reg       <= 1'b0;
      bounces_reg     <= 4'd0;
      h_len_reg       <= 4'd1;
      l_len_reg       <= 4'd1;
      rel_lat_reg     <= 3'd0;
      hold_lat_reg    <= HOLD_BITS'(1);
      press_count_reg <= 8'd0;
      btn_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= lfsr_next;
      cnt_reg         <= cnt_next;
      level_reg       <= level_next;
      bounces_reg     <= bounces_next;
      h_len_reg       <= h_len_next;
      l_len_reg       <= l_len_next;
      rel_lat_reg     <= rel_lat_next;
      hold_lat_reg    <= hold_lat_next;
      press_count_reg <= press_count_next;
      btn_reg         <= btn_next;
    end
  end

  assign btn_out     = btn_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == SETTLE) && (cnt_reg == CNT_ONE);
  assign press_count = press_count_reg;

endmodule

// File: tb/tb_bounce_emulator.sv
// Scoreboard bench for bounce_emulator: a reference LFSR model queues the expected
// waveform per press; a monitor captures btn_out while busy and checks it on done.
`timescale 1ns/1ps
module tb_bounce_emulator;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SETTLE = 32;

  logic       clk_10mhz;
  logic       rst;
  logic       start;
  logic [3:0] bounce_cnt;
  logic [7:0] hold_cycles;
  logic       btn_out;
  logic       busy;
  logic       done;
  logic [7:0] press_count;

  bounce_emulator dut (
    .clk_10mhz  (clk_10mhz),
    .rst        (rst),
    .start      (start),
    .bounce_cnt (bounce_cnt),
    .hold_cycles(hold_cycles),
    .btn_out    (btn_out),
    .busy       (busy),
    .done       (done),
    .press_count(press_count)
  );

  initial clk_10mhz = 1'b0;
  always #50 clk_10mhz = ~clk_10mhz;

  typedef struct {
    logic [1023:0] wave;
    int            len;
    int            rises;
    logic [7:0]    count;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  logic [15:0] m_lfsr = SEED;
  logic [7:0]  m_count = 8'd0;
  int         pb_len_last = 0;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: builds the expected btn_out trace, index 0 = first busy cycle.
  task automatic push_press(input int bc, input int hc);
    exp_t e;
    int   idx;
    int   h;
    int   l;
    e.wave = '0;
    idx = 0;
    for (int b = 0; b < bc; b++) begin
      h = 1 + int'(m_lfsr[2:0]);
      l = 1 + int'(m_lfsr[5:3]);
      m_lfsr = lfsr_adv(m_lfsr);
      for (int k = 0; k < h; k++) begin e.wave[idx] = 1'b1; idx++; end
      idx += l;
    end
    pb_len_last = idx;
    h = (hc == 0) ? 1 : hc;
    for (int k = 0; k < h; k++) begin e.wave[idx] = 1'b1; idx++; end
    for (int b = 0; b < (bc >> 1); b++) begin
      h = 1 + int'(m_lfsr[2:0]);
      l = 1 + int'(m_lfsr[5:3]);
      m_lfsr = lfsr_adv(m_lfsr);
      idx += l;
      for (int k = 0; k < h; k++) begin e.wave[idx] = 1'b1; idx++; end
    end
    e.rises = bc + 1 + (bc >> 1);
`ifdef BOUNCE_GLITCH_EN
    e.wave[idx + 2] = 1'b1;
    e.rises = e.rises + 1;
`endif
    idx += SETTLE;
    e.len = idx;
    m_count = m_count + 8'd1;
    e.count = m_count;
    exp_q.push_back(e);
  endtask

  // Monitor: captures btn_out during busy, pops and compares on each done pulse.
  initial begin
    logic [1023:0] cap;
    int            n;
    int            rises;
    logic          prev_btn;
    logic          prev_busy;
    logic          pend;
    logic [7:0]    pend_cnt;
    int            first_diff;
    exp_t          e;
    cap = '0; n = 0; rises = 0; prev_btn = 1'b0; prev_busy = 1'b0; pend = 1'b0; pend_cnt = 8'd0;
    forever begin
      @(negedge clk_10mhz);
      if (pend) begin
        check("press_count_after_done", int'(press_count), int'(pend_cnt));
        check("busy_low_after_done", int'(busy), 0);
        pend = 1'b0;
      end
      if (busy) begin
        if (!prev_busy) begin cap = '0; n = 0; rises = 0; end
        if (n < 1024) cap[n] = btn_out;
        n++;
        if (btn_out && !prev_btn) rises++;
      end
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", n, e.len);
          check("rising_edges", rises, e.rises);
          first_diff = -1;
          for (int i = 1023; i >= 0; i--) if (cap[i] !== e.wave[i]) first_diff = i;
          check("waveform_first_diff_idx", first_diff, -1);
          $display("press %0d: busy=%0d rises=%0d exp_count=%0d", done_seen, n, rises, e.count);
          pend = 1'b1;
          pend_cnt = e.count;
        end
      end
      prev_btn = btn_out;
      prev_busy = busy;
    end
  end

  task automatic wait_dones(input int target, input int budget);
    int c;
    c = 0;
    while (done_seen < target && c < budget) begin
      @(negedge clk_10mhz);
      c++;
    end
    if (done_seen < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_seen, target);
    end
    repeat (2) @(negedge clk_10mhz);
  endtask

  // Pulses start for one cycle, then scrambles inputs to prove they were latched.
  task automatic issue(input int bc, input int hc);
    push_press(bc, hc);
    bounce_cnt  = 4'(bc);
    hold_cycles = 8'(hc);
    start = 1'b1;
    @(negedge clk_10mhz);
    start = 1'b0;
    bounce_cnt  = 4'hF;
    hold_cycles = 8'h03;
  endtask

  task automatic press(input int bc, input int hc);
    int base;
    base = done_seen;
    issue(bc, hc);
    wait_dones(base + 1, 2000);
  endtask

  task automatic held(input int n, input int bc, input int hc);
    int cnt;
    int c;
    for (int i = 0; i < n; i++) push_press(bc, hc);
    bounce_cnt  = 4'(bc);
    hold_cycles = 8'(hc);
    start = 1'b1;
    cnt = 0;
    c = 0;
    while (cnt < n && c < n * 80 + 200) begin
      @(negedge clk_10mhz);
      c++;
      if (done) cnt++;
    end
    start = 1'b0;
    check("held_start_presses", cnt, n);
    repeat (4) @(negedge clk_10mhz);
  endtask

  initial begin
    int base;
    int c;
    rst = 1'b1; start = 1'b0; bounce_cnt = 4'd0; hold_cycles = 8'd0;
    repeat (3) @(negedge clk_10mhz);
    check("reset_btn_out", int'(btn_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_press_count", int'(press_count), 0);
    rst = 1'b0;
    @(negedge clk_10mhz);

    // Plain hold, then bounce patterns of various lengths.
    press(0, 20);
    press(8, 50);
    press(1, 5);
    press(3, 1);
    press(15, 255);

    // start toggled while busy and asserted on the done cycle must not add a press.
    base = done_seen;
    issue(2, 10);
    c = 0;
    while (c < 1000) begin
      @(negedge clk_10mhz);
      c++;
      if (done) begin
        start = 1'b1;
        @(negedge clk_10mhz);
        start = 1'b0;
        break;
      end
      start = ~start;
    end
    start = 1'b0;
    repeat (40) @(negedge clk_10mhz);
    check("busy_start_single_press", done_seen - base, 1);
    check("busy_start_press_count", int'(press_count), int'(m_count));
    check("busy_start_idle", int'(busy), 0);

    // Reset in the middle of HOLD aborts, then the seed waveform replays.
    rst = 1'b1;
    @(negedge clk_10mhz);
    rst = 1'b0;
    exp_q.delete(); m_lfsr = SEED; m_count = 8'd0;
    base = done_seen;
    issue(4, 100);
    repeat (pb_len_last + 49) @(negedge clk_10mhz);
    rst = 1'b1;
    exp_q.delete(); m_lfsr = SEED; m_count = 8'd0;
    @(negedge clk_10mhz);
    check("abort_btn_out", int'(btn_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_press_count", int'(press_count), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_10mhz);
    check("abort_no_done", done_seen - base, 0);
    press(4, 100);

    // Held start with zero hold, then run the counter up to and past 255.
    held(5, 0, 0);
    check("held_press_count", int'(press_count), int'(m_count));
    held(255 - int'(m_count), 0, 0);
    check("preload_press_count", int'(press_count), 255);
    press(0, 0);
    check("wrap_press_count", int'(press_count), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
